shift_controller: RTL and testbench

SHIFT_CONTROLLER -- requirements
Module: shift_controller

---
 rtl/shift_controller_pkg.sv | 43 ++++
 rtl/shift_settle_timer.sv | 35 +++
 rtl/shift_controller.sv | 165 ++++++++++++++++
 tb/tb_shift_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_controller_pkg
// Brief   : Lever codes, FSM state type, limit bounds and lever-step helper.
// Revision: 1.0
// ============================================================================
package shift_controller_pkg;

  localparam logic [3:0] GEAR_P = 4'd3;
  localparam logic [3:0] GEAR_R = 4'd6;
  localparam logic [3:0] GEAR_N = 4'd9;
  localparam logic [3:0] GEAR_D = 4'd12;

  localparam logic [2:0] LIMIT_MIN = 3'd1;
  localparam logic [2:0] LIMIT_MAX = 3'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_TRANSIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] gear;
  } step_t;

  // Neighbouring lever position in P-R-N-D order; invalid past either end.
  function automatic step_t gear_step(input logic [3:0] g, input logic up);
    step_t s;
    s.valid = 1'b1;
    s.gear  = g;
    case (g)
      GEAR_P:  if (up) s.gear = GEAR_R; else s.valid = 1'b0;
      GEAR_R:  s.gear = up ? GEAR_N : GEAR_P;
      GEAR_N:  s.gear = up ? GEAR_D : GEAR_R;
      GEAR_D:  if (up) s.valid = 1'b0; else s.gear = GEAR_N;
      default: s.valid = 1'b0;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_settle_timer.sv
`default_nettype none
// ============================================================================
// Module  : shift_settle_timer
// Brief   : Saturating 4-bit tick counter; flags the SETTLE_TICKS-th tick.
// Revision: 1.0
// ============================================================================
module shift_settle_timer #(
  parameter int SETTLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_tick,
  output logic o_done
);

  localparam logic [3:0] C_LAST = 4'(SETTLE_TICKS - 1);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_clear) begin
      r_count <= 4'd0;
    end else if (i_en && i_tick && (r_count != 4'hF)) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_done = i_en && i_tick && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/shift_controller.sv
`default_nettype none
// ============================================================================
// Module  : shift_controller
// Brief   : P/R/N/D lever controller with neutral transit and low-gear limit.
//           Optional SHIFT_AUTO_PARK_EN: engine stop at standstill forces P.
// Revision: 1.0
// ============================================================================
module shift_controller
  import shift_controller_pkg::*;
#(
  parameter int SETTLE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       engine_on,
  input  logic       tick_speed,
  input  logic [7:0] speed,
  input  logic       is_brake_normal,
  input  logic       shift_up_req,
  input  logic       shift_down_req,
  input  logic       low_toggle_req,
  input  logic       limit_up_req,
  input  logic       limit_down_req,
  output logic [3:0] current_gear,
  output logic       is_low_gear_mode,
  output logic [2:0] max_gear_limit,
  output logic       shift_busy,
  output logic       shift_reject
);

  state_t     r_state,  w_state_nxt;
  logic [3:0] r_gear,   w_gear_nxt;
  logic [3:0] r_target, w_target_nxt;
  logic       r_low,    w_low_nxt;
  logic [2:0] r_limit,  w_limit_nxt;
  logic       r_busy,   w_busy_nxt;
  logic       r_reject, w_reject_nxt;

  logic  w_clear;
  logic  w_done;
  logic  w_any_shift;
  logic  w_shift_ok;
  logic  w_leave_ok;
  logic  w_enter_ok;
  step_t w_step;

`ifdef SHIFT_AUTO_PARK_EN
  logic r_engine_q;
  logic w_park;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_engine_q <= 1'b0;
    else     r_engine_q <= engine_on;
  end

  assign w_park     = r_engine_q && !engine_on && (speed == 8'd0);
  assign w_shift_ok = engine_on;
`else
  logic w_unused_engine;
  assign w_unused_engine = engine_on;
  assign w_shift_ok      = 1'b1;
`endif

  shift_settle_timer #(
    .SETTLE_TICKS (SETTLE_TICKS)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (r_state == ST_TRANSIT),
    .i_tick  (tick_speed),
    .o_done  (w_done)
  );

  assign w_any_shift = shift_up_req | shift_down_req;
  assign w_step      = gear_step(r_gear, shift_up_req);
  assign w_leave_ok  = (r_gear != GEAR_P) || (is_brake_normal && (speed == 8'd0));
  assign w_enter_ok  = ((w_step.gear != GEAR_R) && (w_step.gear != GEAR_P)) || (speed == 8'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_gear_nxt   = r_gear;
    w_target_nxt = r_target;
    w_low_nxt    = r_low;
    w_limit_nxt  = r_limit;
    w_busy_nxt   = r_busy;
    w_reject_nxt = 1'b0;
    w_clear      = 1'b0;

    // Toggle first so an accepted shift out of D below still clears low mode.
    if (low_toggle_req) begin
      if ((r_state == ST_IDLE) && (r_gear == GEAR_D)) w_low_nxt = ~r_low;
      else                                           w_reject_nxt = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_any_shift) begin
          if ((shift_up_req && shift_down_req) || !w_shift_ok || !w_step.valid ||
              !w_leave_ok || !w_enter_ok) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_target_nxt = w_step.gear;
            w_gear_nxt   = GEAR_N;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = ST_TRANSIT;
            w_clear      = 1'b1;
            if (r_gear == GEAR_D) w_low_nxt = 1'b0;
          end
        end
      end
      ST_TRANSIT: begin
        if (w_any_shift) w_reject_nxt = 1'b1;
        if (w_done) begin
          w_gear_nxt  = r_target;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (limit_up_req && !limit_down_req && (r_limit != LIMIT_MAX)) w_limit_nxt = r_limit + 3'd1;
    if (limit_down_req && !limit_up_req && (r_limit != LIMIT_MIN)) w_limit_nxt = r_limit - 3'd1;

`ifdef SHIFT_AUTO_PARK_EN
    if (w_park) begin
      w_gear_nxt   = GEAR_P;
      w_busy_nxt   = 1'b0;
      w_low_nxt    = 1'b0;
      w_state_nxt  = ST_IDLE;
      w_reject_nxt = 1'b0;
      w_clear      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gear   <= GEAR_P;
      r_target <= GEAR_P;
      r_low    <= 1'b0;
      r_limit  <= LIMIT_MAX;
      r_busy   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gear   <= w_gear_nxt;
      r_target <= w_target_nxt;
      r_low    <= w_low_nxt;
      r_limit  <= w_limit_nxt;
      r_busy   <= w_busy_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  assign current_gear     = r_gear;
  assign is_low_gear_mode = r_low;
  assign max_gear_limit   = r_limit;
  assign shift_busy       = r_busy;
  assign shift_reject     = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_shift_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_controller
// Brief   : Directed self-checking bench with a lever-position reference model.
// Revision: 1.0
// ============================================================================
module tb_shift_controller;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       engine_on = 1'b1;
  logic       tick_speed = 1'b0;
  logic [7:0] speed = 8'd0;
  logic       brake = 1'b0;
  logic       up = 1'b0, dn = 1'b0, ltog = 1'b0, lup = 1'b0, ldn = 1'b0;

  logic [3:0] current_gear;
  logic       is_low_gear_mode;
  logic [2:0] max_gear_limit;
  logic       shift_busy;
  logic       shift_reject;

  int n_tests = 0;
  int n_fail  = 0;

  shift_controller #(.SETTLE_TICKS(SETTLE)) dut (
    .clk              (clk),
    .rst              (rst),
    .engine_on        (engine_on),
    .tick_speed       (tick_speed),
    .speed            (speed),
    .is_brake_normal  (brake),
    .shift_up_req     (up),
    .shift_down_req   (dn),
    .low_toggle_req   (ltog),
    .limit_up_req     (lup),
    .limit_down_req   (ldn),
    .current_gear     (current_gear),
    .is_low_gear_mode (is_low_gear_mode),
    .max_gear_limit   (max_gear_limit),
    .shift_busy       (shift_busy),
    .shift_reject     (shift_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: lever position as index 0..3 (P,R,N,D), code = 3*(index+1).
  int m_gear = 3, m_target = 3, m_low = 0, m_limit = 3, m_busy = 0, m_reject = 0;
  int m_ticks = 0, m_eng_prev = 0;

  always @(posedge clk or posedge rst) begin : model
    int  old_gear, old_busy, idx, nidx;
    bit  rej, acc, legal, shift_ok;
    if (rst) begin
      m_gear = 3; m_target = 3; m_low = 0; m_limit = 3;
      m_busy = 0; m_reject = 0; m_ticks = 0; m_eng_prev = 0;
    end else begin
      old_gear = m_gear;
      old_busy = m_busy;
      rej = 0;
      acc = 0;
`ifdef SHIFT_AUTO_PARK_EN
      shift_ok = engine_on;
`else
      shift_ok = 1;
`endif
      if (old_busy != 0) begin
        if (up || dn) rej = 1;
        if (tick_speed) begin
          m_ticks++;
          if (m_ticks == SETTLE) begin
            m_gear = m_target;
            m_busy = 0;
          end
        end
      end else if (up || dn) begin
        if ((up && dn) || !shift_ok) begin
          rej = 1;
        end else begin
          idx   = old_gear / 3 - 1;
          nidx  = up ? idx + 1 : idx - 1;
          legal = (nidx >= 0) && (nidx <= 3) &&
                  ((idx != 0) || (brake && speed == 0)) &&
                  ((nidx >= 2) || (speed == 0));
          if (legal) begin
            acc      = 1;
            m_target = (nidx + 1) * 3;
            m_gear   = 9;
            m_busy   = 1;
            m_ticks  = 0;
          end else begin
            rej = 1;
          end
        end
      end
      if (ltog) begin
        if (old_busy == 0 && old_gear == 12) m_low = 1 - m_low;
        else rej = 1;
      end
      if (acc && old_gear == 12) m_low = 0;
      if (lup && !ldn && m_limit < 3) m_limit++;
      if (ldn && !lup && m_limit > 1) m_limit--;
`ifdef SHIFT_AUTO_PARK_EN
      if (m_eng_prev != 0 && !engine_on && speed == 0) begin
        m_gear = 3; m_busy = 0; m_low = 0; rej = 0;
      end
`endif
      m_eng_prev = int'(engine_on);
      m_reject   = int'(rej);
    end
  end

  always @(negedge clk) begin
    chk("model_gear",   int'(current_gear),     m_gear);
    chk("model_busy",   int'(shift_busy),       m_busy);
    chk("model_reject", int'(shift_reject),     m_reject);
    chk("model_low",    int'(is_low_gear_mode), m_low);
    chk("model_limit",  int'(max_gear_limit),   m_limit);
  end

  task automatic cyc(input bit u, input bit d, input bit t, input bit l, input bit lu, input bit ld);
    up = u; dn = d; tick_speed = t; ltog = l; lup = lu; ldn = ld;
    @(posedge clk);
    #1;
    up = 0; dn = 0; tick_speed = 0; ltog = 0; lup = 0; ldn = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gear",   int'(current_gear), 3);
    chk("rst_busy",   int'(shift_busy), 0);
    chk("rst_limit",  int'(max_gear_limit), 3);
    chk("rst_low",    int'(is_low_gear_mode), 0);
    chk("rst_reject", int'(shift_reject), 0);
    rst = 0;
    @(posedge clk);
    #1;

    // Leaving P without brake
    brake = 0;
    cyc(1, 0, 0, 0, 0, 0);
    chk("p_nobrake_reject", int'(shift_reject), 1);
    chk("p_nobrake_gear",   int'(current_gear), 3);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reject_one_clk",   int'(shift_reject), 0);

    // P -> R through neutral
    brake = 1;
    cyc(1, 0, 0, 0, 0, 0);
    chk("p_up_gear", int'(current_gear), 9);
    chk("p_up_busy", int'(shift_busy), 1);
    ticks(3);
    chk("tick3_busy", int'(shift_busy), 1);
    ticks(1);
    chk("tick4_gear", int'(current_gear), 6);
    chk("tick4_busy", int'(shift_busy), 0);

    cyc(1, 0, 0, 0, 0, 0); ticks(4);
    chk("r_to_n", int'(current_gear), 9);
    cyc(1, 0, 0, 0, 0, 0); ticks(4);
    chk("n_to_d", int'(current_gear), 12);

    // Low mode and limits
    cyc(0, 0, 0, 1, 0, 0);
    chk("low_on", int'(is_low_gear_mode), 1);
    cyc(0, 0, 0, 0, 0, 1); chk("limit_2", int'(max_gear_limit), 2);
    cyc(0, 0, 0, 0, 0, 1); chk("limit_1", int'(max_gear_limit), 1);
    cyc(0, 0, 0, 0, 0, 1); chk("limit_sat_1", int'(max_gear_limit), 1);
    chk("limit_sat_noreject", int'(shift_reject), 0);
    cyc(0, 0, 0, 0, 1, 1); chk("limit_both", int'(max_gear_limit), 1);
    cyc(0, 0, 0, 0, 1, 0); chk("limit_up", int'(max_gear_limit), 2);

    // D -> N while moving, then N -> R refused
    speed = 8'd40;
    cyc(0, 1, 0, 0, 0, 0);
    chk("d_down_low_clear", int'(is_low_gear_mode), 0);
    chk("d_down_gear", int'(current_gear), 9);
    ticks(4);
    chk("d_down_settled_n", int'(current_gear), 9);
    chk("d_down_busy", int'(shift_busy), 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("n_to_r_moving_reject", int'(shift_reject), 1);
    chk("n_to_r_moving_gear", int'(current_gear), 9);

    // Request during transit does not disturb the shift
    speed = 8'd0;
    cyc(0, 1, 0, 0, 0, 0);
    ticks(2);
    cyc(1, 0, 0, 0, 0, 0);
    chk("transit_req_reject", int'(shift_reject), 1);
    chk("transit_req_busy", int'(shift_busy), 1);
    ticks(1);
    chk("transit_tick3_busy", int'(shift_busy), 1);
    ticks(1);
    chk("transit_done_gear", int'(current_gear), 6);

    // Reset mid-transit
    cyc(1, 0, 0, 0, 0, 0);
    ticks(1);
    rst = 1;
    #1;
    chk("rst_transit_gear", int'(current_gear), 3);
    chk("rst_transit_busy", int'(shift_busy), 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;

    cyc(0, 0, 0, 1, 0, 0); chk("low_in_p_reject", int'(shift_reject), 1);
    cyc(1, 1, 0, 0, 0, 0); chk("up_down_reject", int'(shift_reject), 1);
    cyc(0, 0, 0, 0, 1, 0); chk("limit_sat_3", int'(max_gear_limit), 3);
    chk("limit_sat_3_noreject", int'(shift_reject), 0);
    cyc(0, 1, 0, 0, 0, 0); chk("p_down_reject", int'(shift_reject), 1);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      ticks(4);
    end
    chk("p_to_d", int'(current_gear), 12);
    cyc(1, 0, 0, 0, 0, 0); chk("d_up_reject", int'(shift_reject), 1);

    // Engine stop at standstill
    engine_on = 0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
`ifdef SHIFT_AUTO_PARK_EN
    chk("engine_off_gear", int'(current_gear), 3);
`else
    chk("engine_off_gear", int'(current_gear), 12);
    cyc(0, 1, 0, 0, 0, 0);
    ticks(4);
    chk("coast_to_n", int'(current_gear), 9);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
